regfile_scoreboard_imm: RTL and testbench
=========================================

Name: regfile_scoreboard_imm

Overview:
Parametrised successor to the decode-stage register file and immediate generator, built for the pipelined core. It holds the architectural register file with write-back bypass and generates the immediate for every RV32I format, including the U-type and J-type formats. A per-register busy scoreboard tracks in-flight writes and raises a stall for RAW and WAW hazards. It sits between the fetch/decode latch and the execute stage; write-back drives it from the end of the pipe.

Parameters:
XLEN, 32, data width of registers, write data and immediate (≥32)
NREGS, 32, number of architectural registers; power of 2, ≤32; AW = clog2(NREGS)
BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
inst  in  32  instruction in decode
issue_valid  in  1  decode is presenting inst for issue this cycle
wb_valid  in  1  write-back request
wb_rd  in  AW  write-back destination
wb_data  in  XLEN  write-back data
rs1_data  out  XLEN  operand 1
rs2_data  out  XLEN  operand 2
imm  out  XLEN  sign-extended immediate
stall  out  1  hazard: inst must not issue this cycle
busy_vec  out  NREGS  scoreboard state, bit r = write to r pending

Behaviour:
- Clock and reset: clk is the clock; reset rst is synchronous and active-low.
- Reset (rst=0 at posedge): all registers are set to 0 and busy_vec is set to 0. The reset has priority over any wb or issue in the same cycle. Combinational outputs then follow from the reset state.
- Decode fields: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7], opcode=inst[6:0], truncated to AW bits.
- Register index 0 reads 0, is never written and is never busy.
- use_rs1 for these opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
- use_rs2 for these opcodes: 0110011, 0100011, 1100011.
- writes_rd for these opcodes, with rd≠0: 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111.
- Immediate, combinational, zero latency:
  - I-type (0010011, 0000011, 1100111): sext(inst[31:20]).
  - S-type: sext({inst[31:25], inst[11:7]}).
  - B-type: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}.
  - J-type: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - R-type and unknown opcodes: 0. There are no latches; every path assigns imm.
- Reads: combinational. If BYPASS=1 and wb_valid && wb_rd==rsN && rsN≠0, the port returns wb_data; otherwise it returns the stored value.
- Write: at posedge, if wb_valid && wb_rd≠0, then reg[wb_rd] <= wb_data.
- busy_eff[r] = busy[r] && !(wb_valid && wb_rd==r). A same-cycle write-back resolves the hazard only when BYPASS=1; when BYPASS=0, busy_eff = busy.
- stall = issue_valid && ((use_rs1 && busy_eff[rs1]) || (use_rs2 && busy_eff[rs2]) || (writes_rd && busy_eff[rd])).
- Scoreboard update at posedge:
  - busy[wb_rd] is cleared on wb_valid.
  - busy[rd] is set when issue_valid && !stall && writes_rd.
  - If set and clear hit the same register in the same cycle, set wins.
- WAW is prevented by stall, so at most one write per register is in flight.
- A wb_valid to a non-busy register is legal: the data is written and the scoreboard is unchanged.
- Reset mid-operation discards all pending busy bits. The pipeline is flushed externally.

Optional Feature:
REGFILE_DEBUG_PORT_EN:
- Defined: adds input dbg_addr[AW] and output dbg_data[XLEN], an asynchronous read of the stored register with no bypass; dbg_addr 0 returns 0.
- Undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - opcode localparams: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - an imm-format enum: IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J.
- One natural sub-module: imm_gen, purely combinational, taking inst and producing imm, parametrised on XLEN.
- Scoreboard and register array stay in the top module.

Test Plan:
1. Reset: rst=0 for one cycle, then read all registers → rs1_data=rs2_data=0, busy_vec=0, stall=0.
2. Write and bypass: wb x5=0xDEADBEEF while inst reads rs1=x5 in the same cycle → rs1_data=0xDEADBEEF (BYPASS=1); next cycle, with no wb, still 0xDEADBEEF. A write to x0 leaves x0 reading 0.
3. RAW hazard:
   - issue `addi x3,x0,7` → busy_vec[3]=1 after the posedge;
   - next cycle, `add x4,x3,x3` → stall=1;
   - when wb x3=7 arrives, stall=0 that cycle and rs1_data=7.
4. WAW and set-wins:
   - with x6 busy, issue writing x6 → stall=1;
   - in the cycle wb x6 arrives, an issue writing x6 → no stall; busy_vec[6] is still 1 after the posedge.
5. Immediates (inst → imm):
   - 0xFFF00093 → 0xFFFFFFFF;
   - 0xFE000EA3 → 0xFFFFFFFD;
   - 0x123450B7 → 0x12345000;
   - 0x8000006F → 0xFFF00000.
6. Reset mid-flight: set busy on x1 and x2, then rst=0 → busy_vec=0 and stall=0 for a dependent inst.

Source files
------------

// File: rtl/regfile_scoreboard_imm_pkg.sv
// Shared definitions for regfile_scoreboard_imm: RV32I opcodes and the
// immediate-format classification used by the immediate generator.
package regfile_scoreboard_imm_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  function automatic imm_fmt_t imm_format(input logic [6:0] opcode);
    imm_fmt_t fmt;
    fmt = IMM_NONE;
    case (opcode)
      OP_I, OP_LOAD, OP_JALR: fmt = IMM_I;
      OP_STORE:               fmt = IMM_S;
      OP_BRANCH:              fmt = IMM_B;
      OP_LUI, OP_AUIPC:       fmt = IMM_U;
      OP_JAL:                 fmt = IMM_J;
      default:                fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_imm_imm_gen.sv
// Combinational RV32I immediate generator; every format is sign-extended
// to XLEN, R-type and unknown opcodes yield zero.
module regfile_scoreboard_imm_imm_gen
  import regfile_scoreboard_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  imm_fmt_t fmt;

  assign fmt = imm_format(inst[6:0]);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = XLEN'($signed(inst[31:20]));
      IMM_S:   imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      IMM_B:   imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      IMM_U:   imm = XLEN'($signed({inst[31:12], 12'b0}));
      IMM_J:   imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/regfile_scoreboard_imm.sv
// Decode-stage register file with write-back bypass, busy scoreboard for
// RAW/WAW stalls, and immediate generation. REGFILE_DEBUG_PORT_EN adds a debug read port.
module regfile_scoreboard_imm
  import regfile_scoreboard_imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             issue_valid,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  imm,
  output logic             stall,
  output logic [NREGS-1:0] busy_vec
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [AW-1:0]    dbg_addr,
  output logic [XLEN-1:0]  dbg_data
`endif
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_eff;
  logic [AW-1:0]    rs1, rs2, rd;
  logic [6:0]       opcode;
  logic             use_rs1, use_rs2, writes_op, writes_rd;
  logic             rs1_bypass, rs2_bypass, issue_fire;

  assign rs1    = inst[15 +: AW];
  assign rs2    = inst[20 +: AW];
  assign rd     = inst[7 +: AW];
  assign opcode = inst[6:0];

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_op = 1'b0;
    case (opcode)
      OP_R:                    begin use_rs1 = 1'b1; use_rs2 = 1'b1; writes_op = 1'b1; end
      OP_I, OP_LOAD, OP_JALR:  begin use_rs1 = 1'b1; writes_op = 1'b1; end
      OP_STORE, OP_BRANCH:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_JAL, OP_LUI, OP_AUIPC: writes_op = 1'b1;
      default: ;
    endcase
  end

  assign writes_rd = writes_op && (rd != '0);

  // A write-back landing this cycle only clears the hazard if its data is forwarded.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy_eff
      assign busy_eff[gi] = busy[gi] && !((BYPASS != 0) && wb_valid && (wb_rd == AW'(gi)));
    end
  endgenerate

  assign stall = issue_valid && ((use_rs1 && busy_eff[rs1]) ||
                                 (use_rs2 && busy_eff[rs2]) ||
                                 (writes_rd && busy_eff[rd]));
  assign issue_fire = issue_valid && !stall && writes_rd;
  assign busy_vec   = busy;

  assign rs1_bypass = (BYPASS != 0) && wb_valid && (wb_rd == rs1);
  assign rs2_bypass = (BYPASS != 0) && wb_valid && (wb_rd == rs2);
  assign rs1_data   = (rs1 == '0) ? '0 : (rs1_bypass ? wb_data : regs[rs1]);
  assign rs2_data   = (rs2 == '0) ? '0 : (rs2_bypass ? wb_data : regs[rs2]);

  // The issue set is written after the write-back clear so it wins on a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      if (wb_valid && (wb_rd != '0)) regs[wb_rd] <= wb_data;
      if (wb_valid) busy[wb_rd] <= 1'b0;
      if (issue_fire) busy[rd] <= 1'b1;
    end
  end

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
`endif

  regfile_scoreboard_imm_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (inst),
    .imm  (imm)
  );

endmodule

// File: tb/tb_regfile_scoreboard_imm.sv
// Directed plus randomized checks of regfile_scoreboard_imm (default
// parameters) against a behavioural register/scoreboard model.
module tb_regfile_scoreboard_imm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        issue_valid;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rs1_data, rs2_data, imm;
  logic        stall;
  logic [31:0] busy_vec;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  regfile_scoreboard_imm dut (
    .clk         (clk),
    .rst         (rst),
    .inst        (inst),
    .issue_valid (issue_valid),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .stall       (stall),
    .busy_vec    (busy_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_r(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    return {7'b0, s2, s1, 3'b0, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] d, input logic [4:0] s1, input logic [11:0] k);
    return {k, s1, 3'b0, d, 7'b0010011};
  endfunction

  function automatic bit reads1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
  endfunction

  function automatic bit reads2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit writes(input logic [6:0] op, input logic [4:0] d);
    return (d != 0) && (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                                   7'b1100111, 7'b0110111, 7'b0010111});
  endfunction

  // Immediate value rebuilt arithmetically from the bit positions of each format.
  function automatic logic [31:0] model_imm(input logic [31:0] i);
    int v;
    v = 0;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: v = $signed(i) >>> 20;
      7'b0100011: v = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
      7'b1100011: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      7'b0110111, 7'b0010111: v = int'(i & 32'hFFFFF000);
      7'b1101111: v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_valid && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit pending(input logic [4:0] r);
    return m_busy[r] && !(wb_valid && wb_rd == r);
  endfunction

  function automatic bit model_stall();
    logic [6:0] op;
    op = inst[6:0];
    return issue_valid && ((reads1(op) && pending(inst[19:15])) ||
                           (reads2(op) && pending(inst[24:20])) ||
                           (writes(op, inst[11:7]) && pending(inst[11:7])));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic settle_and_check();
    #1;
    check("rs1_data", rs1_data, model_read(inst[19:15]));
    check("rs2_data", rs2_data, model_read(inst[24:20]));
    check("imm", imm, model_imm(inst));
    check("stall", {31'b0, stall}, {31'b0, model_stall()});
    check("busy_vec", busy_vec, m_busy);
  endtask

  task automatic tick();
    bit st;
    st = model_stall();
    @(posedge clk);
    if (!rst) begin
      m_busy = '0;
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
    end else begin
      if (wb_valid && wb_rd != 0) m_regs[wb_rd] = wb_data;
      if (wb_valid) m_busy[wb_rd] = 1'b0;
      if (issue_valid && !st && writes(inst[6:0], inst[11:7])) m_busy[inst[11:7]] = 1'b1;
    end
    #1;
  endtask

  logic [31:0] imm_inst [4] = '{32'hFFF00093, 32'hFE000EA3, 32'h123450B7, 32'h8000006F};
  logic [31:0] imm_exp  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h12345000, 32'hFFF00000};
  logic [6:0]  ops      [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};

  initial begin
    logic [4:0] q [$];
    rst = 1'b0; inst = 32'h00000013; issue_valid = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    m_busy = '0;
    for (int r = 0; r < 32; r++) m_regs[r] = '0;

    // Reset for one cycle, then every register reads zero and nothing is busy.
    tick();
    rst = 1'b1;
    issue_valid = 1'b1;
    $display("step: reset readback");
    for (int r = 0; r < 32; r++) begin
      inst = mk_r(5'd0, 5'(r), 5'(r));
      settle_and_check();
      check("reset_rs1", rs1_data, 32'd0);
      check("reset_rs2", rs2_data, 32'd0);
      tick();
    end
    check("reset_busy", busy_vec, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);

    $display("step: write and bypass");
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; inst = mk_r(5'd0, 5'd5, 5'd0);
    settle_and_check();
    check("bypass_x5", rs1_data, 32'hDEADBEEF);
    tick();
    wb_valid = 1'b0;
    settle_and_check();
    check("stored_x5", rs1_data, 32'hDEADBEEF);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h00000123; inst = mk_r(5'd0, 5'd0, 5'd5);
    settle_and_check();
    check("x0_bypass", rs1_data, 32'd0);
    tick();
    wb_valid = 1'b0;
    settle_and_check();
    check("x0_stored", rs1_data, 32'd0);
    check("x5_rs2", rs2_data, 32'hDEADBEEF);
    tick();

    $display("step: RAW hazard on x3");
    issue_valid = 1'b1; inst = mk_i(5'd3, 5'd0, 12'd7);
    settle_and_check();
    check("addi_no_stall", {31'b0, stall}, 32'd0);
    tick();
    inst = mk_r(5'd4, 5'd3, 5'd3);
    settle_and_check();
    check("busy3_set", {31'b0, busy_vec[3]}, 32'd1);
    check("raw_stall", {31'b0, stall}, 32'd1);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd7;
    settle_and_check();
    check("raw_resolved", {31'b0, stall}, 32'd0);
    check("raw_fwd", rs1_data, 32'd7);
    tick();
    issue_valid = 1'b0; wb_rd = 5'd4; wb_data = 32'd14;
    settle_and_check();
    tick();
    wb_valid = 1'b0;

    $display("step: WAW hazard and set-wins on x6");
    issue_valid = 1'b1; inst = mk_i(5'd6, 5'd0, 12'd1);
    settle_and_check();
    tick();
    inst = mk_i(5'd6, 5'd0, 12'd2);
    settle_and_check();
    check("waw_stall", {31'b0, stall}, 32'd1);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'd1;
    settle_and_check();
    check("waw_wb_no_stall", {31'b0, stall}, 32'd0);
    tick();
    wb_valid = 1'b0; issue_valid = 1'b0;
    settle_and_check();
    check("set_wins_busy6", {31'b0, busy_vec[6]}, 32'd1);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'd2;
    settle_and_check();
    tick();
    wb_valid = 1'b0;

    $display("step: immediate formats");
    for (int k = 0; k < 4; k++) begin
      inst = imm_inst[k];
      settle_and_check();
      check("imm_const", imm, imm_exp[k]);
      tick();
    end

    $display("step: reset with writes in flight");
    issue_valid = 1'b1; inst = mk_i(5'd1, 5'd0, 12'd1);
    settle_and_check();
    tick();
    inst = mk_i(5'd2, 5'd0, 12'd2);
    settle_and_check();
    tick();
    issue_valid = 1'b0;
    settle_and_check();
    check("busy_x1_x2", {30'b0, busy_vec[2:1]}, 32'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1; issue_valid = 1'b1; inst = mk_r(5'd7, 5'd1, 5'd2);
    settle_and_check();
    check("flush_busy", busy_vec, 32'd0);
    check("flush_stall", {31'b0, stall}, 32'd0);
    tick();

    $display("step: randomized traffic");
    for (int n = 0; n < 400; n++) begin
      logic [31:0] w;
      q.delete();
      for (int r = 1; r < 8; r++) if (m_busy[r]) q.push_back(5'(r));
      w = $urandom;
      w[6:0]   = ops[$urandom_range(0, 9)];
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      inst = w;
      issue_valid = ($urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 1) != 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) wb_rd = q[$urandom_range(0, q.size() - 1)];
      else wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      rst = ($urandom_range(0, 63) != 0);
      settle_and_check();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
